// File: rtl/pc_fetch_sequencer.sv
// Purpose : owns the RV32 program counter, runs the single-outstanding imem
//           fetch handshake and picks the next PC when the presented
//           instruction retires.
// Latency : request in cycle n with same-cycle ack -> inst_valid in cycle n+1.
//           Zero-wait throughput is one instruction per 2 cycles.
// Backpressure: stall holds the presented instruction, the PC and any
//           redirect or trap request. imem_req stays up with a stable address
//           until imem_ack arrives.
//
// Ports:
//   clk, reset                     clock, async active-high reset
//   stall                          decode/execute not ready
//   redirect_valid, redirect_pc    branch/jump target for presented inst
//   trap_valid, trap_vector        exception/ecall and handler address
//   imem_req, imem_addr            fetch request and address (== pc)
//   imem_ack, imem_rdata           fetch response
//   inst_valid, inst, inst_pc      instruction presented to decode
//   pc                             current fetch PC
//   misalign_trap                  one-cycle pulse on misaligned redirect
module pc_fetch_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_vector,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             inst_valid,
  output logic [31:0]      inst,
  output logic [WIDTH-1:0] inst_pc,
  output logic [WIDTH-1:0] pc,
  output logic             misalign_trap
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t state;

  assign imem_addr = pc;

  // imem_req and inst_valid are registered copies of (state == FETCH) and
  // (state == ISSUE); they change on the same edges as the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= BOOT;
      pc            <= RESET_VECTOR;
      imem_req      <= 1'b0;
      inst_valid    <= 1'b0;
      misalign_trap <= 1'b0;
      inst          <= '0;
      inst_pc       <= '0;
    end else begin
      // misalign_trap is a pulse: it is only raised in the cycle
      // immediately following the retire that caused it.
      misalign_trap <= 1'b0;
      case (state)
        BOOT: begin
          // Any ack still in flight from before reset is dropped here.
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            inst       <= imem_rdata;
            inst_pc    <= pc;
            imem_req   <= 1'b0;
            inst_valid <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // Acks seen here are spurious; nothing is outstanding.
          if (!stall) begin
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            state      <= FETCH;
            if (trap_valid) begin
              pc <= trap_vector;
            end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
              pc            <= trap_vector;
              misalign_trap <= 1'b1;
            end else if (redirect_valid) begin
              pc <= redirect_pc;
            end else begin
              pc <= pc + WIDTH'(4);
            end
          end
        end
        default: begin
          state      <= BOOT;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc;
  logic        misalign_trap;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_fetch[$];
  logic [31:0] exp_ret_pc[$];
  logic [31:0] exp_ret_inst[$];
  logic [31:0] exp_mis[$];

  pc_fetch_sequencer #(.WIDTH(32), .RESET_VECTOR(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_vector    (trap_vector),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .pc             (pc),
    .misalign_trap  (misalign_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a transaction.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (imem_req && imem_ack) begin
          if (exp_fetch.size() == 0) check("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
          else check("fetch_addr", imem_addr, exp_fetch.pop_front());
        end
        if (inst_valid && !stall) begin
          if (exp_ret_pc.size() == 0) check("unexpected_retire", inst_pc, 32'hFFFF_FFFF);
          else begin
            check("retire_pc", inst_pc, exp_ret_pc.pop_front());
            check("retire_inst", inst, exp_ret_inst.pop_front());
          end
        end
        if (misalign_trap) begin
          if (exp_mis.size() == 0) check("unexpected_misalign", {31'b0, misalign_trap}, 32'h0);
          else check("misalign_target", imem_addr, exp_mis.pop_front());
        end
      end
    end
  end

  // Waits (bounded) for a request, holds off ack for 'waits' cycles, then acks.
  task automatic do_fetch(input logic [31:0] addr, input int waits, input int lead);
    int n = 0;
    while (!imem_req && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("fetch_lead", n, lead);
    for (int i = 0; i < waits; i++) begin
      check("req_held", {31'b0, imem_req}, 32'h1);
      check("addr_held", imem_addr, addr);
      @(posedge clk); #1;
    end
    imem_ack   = 1'b1;
    imem_rdata = addr ^ 32'h1357_9BDF;
    exp_fetch.push_back(addr);
    exp_ret_pc.push_back(addr);
    exp_ret_inst.push_back(addr ^ 32'h1357_9BDF);
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
  endtask

  // Holds with stall (driving ignored redirect/trap and spurious acks), then retires.
  task automatic do_retire(input logic [31:0] addr, input int stalls,
                           input logic rv, input logic [31:0] rpc,
                           input logic tv, input logic [31:0] tvec, input logic mis);
    check("inst_valid", {31'b0, inst_valid}, 32'h1);
    check("req_low_issue", {31'b0, imem_req}, 32'h0);
    for (int i = 0; i < stalls; i++) begin
      stall          = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      trap_valid     = 1'b1;
      trap_vector    = 32'hDEAD_0000;
      imem_ack       = 1'b1;
      imem_rdata     = 32'hBAD0_BAD0;
      @(posedge clk); #1;
      check("stall_valid", {31'b0, inst_valid}, 32'h1);
      check("stall_inst_pc", inst_pc, addr);
      check("stall_inst", inst, addr ^ 32'h1357_9BDF);
      check("stall_req_low", {31'b0, imem_req}, 32'h0);
    end
    stall          = 1'b0;
    imem_ack       = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = rv;
    redirect_pc    = rpc;
    trap_valid     = tv;
    trap_vector    = tvec;
    if (mis) exp_mis.push_back(tvec);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    trap_valid     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    trap_valid = 1'b0; trap_vector = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_mis", {31'b0, misalign_trap}, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_pc", pc, 32'h0);
    reset = 1'b0;
    check("boot_idle", {31'b0, imem_req}, 32'h0);

    do_fetch(32'h0, 0, 1);          do_retire(32'h0, 0, 0, 32'h0, 0, 32'h0, 0);
    do_fetch(32'h4, 0, 0);          do_retire(32'h4, 0, 0, 32'h0, 0, 32'h0, 0);
    do_fetch(32'h8, 0, 0);          do_retire(32'h8, 5, 0, 32'h0, 0, 32'h0, 0);
    do_fetch(32'hC, 0, 0);          do_retire(32'hC, 0, 0, 32'h0, 0, 32'h0, 0);
    do_fetch(32'h10, 3, 0);         do_retire(32'h10, 0, 1, 32'h20, 0, 32'h0, 0);
    do_fetch(32'h20, 0, 0);         do_retire(32'h20, 0, 1, 32'h100, 0, 32'h0, 0);
    do_fetch(32'h100, 0, 0);        do_retire(32'h100, 0, 1, 32'h102, 0, 32'h200, 1);
    do_fetch(32'h200, 0, 0);        do_retire(32'h200, 0, 1, 32'h80, 1, 32'h300, 0);
    do_fetch(32'h300, 0, 0);        do_retire(32'h300, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0);
    do_fetch(32'hFFFF_FFFC, 0, 0);  do_retire(32'hFFFF_FFFC, 0, 0, 32'h0, 0, 32'h0, 0);
    do_fetch(32'h0, 0, 0);          do_retire(32'h0, 0, 0, 32'h0, 0, 32'h0, 0);

    // Reset with the fetch of 0x4 outstanding; ack arrives during reset and BOOT.
    check("pre_rst_req", {31'b0, imem_req}, 32'h1);
    check("pre_rst_addr", imem_addr, 32'h4);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_req", {31'b0, imem_req}, 32'h0);
    check("mid_rst_pc", pc, 32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_0004;
    @(posedge clk); #1;
    reset = 1'b0;
    check("boot2_idle", {31'b0, imem_req}, 32'h0);
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    check("boot_ack_dropped", {31'b0, inst_valid}, 32'h0);
    check("restart_addr", imem_addr, 32'h0);
    do_fetch(32'h0, 0, 0);          do_retire(32'h0, 0, 0, 32'h0, 0, 32'h0, 0);
    do_fetch(32'h4, 0, 0);          do_retire(32'h4, 0, 0, 32'h0, 0, 32'h0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("fetch_q_empty", exp_fetch.size(), 32'h0);
    check("retire_q_empty", exp_ret_pc.size(), 32'h0);
    check("misalign_q_empty", exp_mis.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
